// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM address, captures the
// ROM word into the IF/ID register, and traps bad next-PC values into HALT.
module fetch_unit #(
  parameter int unsigned    DATA_WIDTH = 32,
  parameter int unsigned    ADDR_WIDTH = 8,
  parameter logic [31:0]    RESET_PC   = 32'h0000_0000,
  parameter logic [31:0]    NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  pc_src,
  input  logic [DATA_WIDTH-1:0] pc_target,
  input  logic [DATA_WIDTH-1:0] instr_in,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] ifid_instr,
  output logic [DATA_WIDTH-1:0] ifid_pc,
  output logic [DATA_WIDTH-1:0] ifid_pc_plus4,
  output logic                  ifid_valid,
  output logic                  fault,
  output logic [1:0]            fault_cause,
  output logic [DATA_WIDTH-1:0] fault_pc,
  output logic [DATA_WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  localparam logic [DATA_WIDTH-1:0] Four     = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ResetPc  = RESET_PC[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] NopInstr = NOP_INSTR[DATA_WIDTH-1:0];

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [DATA_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [DATA_WIDTH-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic                  fault_q, fault_d;
  logic [1:0]            fault_cause_q, fault_cause_d;
  logic [DATA_WIDTH-1:0] fault_pc_q, fault_pc_d;
  logic [DATA_WIDTH-1:0] fetch_count_q, fetch_count_d;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] cand;
  logic                  cand_misaligned;
  logic                  cand_out_of_range;
  logic                  fault_hit;

  // Next-PC candidate and its fault classification.
  always_comb begin
    pc_plus4 = pc_q + Four;
    if (pc_src) begin
      cand = pc_target;
    end else if (stall) begin
      cand = pc_q;
    end else begin
      cand = pc_plus4;
    end
    cand_misaligned   = (cand[1:0] != 2'b00);
    cand_out_of_range = (cand[DATA_WIDTH-1:ADDR_WIDTH] != '0);
    // The hold value is always legal, so only a changing PC can fault.
    fault_hit = (cand != pc_q) && (cand_misaligned || cand_out_of_range);
  end

  // Next-state for FSM, PC, IF/ID and fault registers.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    fault_d         = fault_q;
    fault_cause_d   = fault_cause_q;
    fault_pc_d      = fault_pc_q;
    fetch_count_d   = fetch_count_q;

    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end
      StRun: begin
        if (fault_hit) begin
          fault_d       = 1'b1;
          fault_cause_d = {cand_out_of_range, cand_misaligned};
          fault_pc_d    = cand;
          ifid_instr_d  = NopInstr;
          ifid_valid_d  = 1'b0;
          state_d       = StHalt;
        end else begin
          pc_d = cand;
          if (pc_src || flush) begin
            ifid_instr_d = NopInstr;
            ifid_valid_d = 1'b0;
          end else if (!stall) begin
            ifid_instr_d    = instr_in;
            ifid_pc_d       = pc_q;
            ifid_pc_plus4_d = pc_plus4;
            ifid_valid_d    = 1'b1;
            fetch_count_d   = fetch_count_q + 1'b1;
          end
        end
      end
      StHalt: begin
        ifid_instr_d = NopInstr;
        ifid_valid_d = 1'b0;
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StBoot;
      pc_q            <= ResetPc;
      ifid_instr_q    <= NopInstr;
      ifid_pc_q       <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_valid_q    <= 1'b0;
      fault_q         <= 1'b0;
      fault_cause_q   <= 2'b00;
      fault_pc_q      <= '0;
      fetch_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      fault_q         <= fault_d;
      fault_cause_q   <= fault_cause_d;
      fault_pc_q      <= fault_pc_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  assign pc_out        = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;
  assign fault         = fault_q;
  assign fault_cause   = fault_cause_q;
  assign fault_pc      = fault_pc_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an asynchronous ROM model and a queue of
// expected post-edge states.
module tb_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, pc_src;
  logic [31:0] pc_target, instr_in;
  logic [31:0] pc_out, ifid_instr, ifid_pc, ifid_pc_plus4, fault_pc, fetch_count;
  logic        ifid_valid, fault;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] p4;
    logic        v;
    logic        f;
    logic [1:0]  c;
    logic [31:0] fpc;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  logic [31:0] rom [64];

  always #5 clk = ~clk;

  assign instr_in = rom[pc_out[7:2]];

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .pc_src       (pc_src),
    .pc_target    (pc_target),
    .instr_in     (instr_in),
    .pc_out       (pc_out),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid   (ifid_valid),
    .fault        (fault),
    .fault_cause  (fault_cause),
    .fault_pc     (fault_pc),
    .fetch_count  (fetch_count)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return 32'hA000_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue what must hold after the edge, then compare.
  task automatic step(input logic r, input logic s, input logic f, input logic ps,
                      input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_ipc, input logic [31:0] e_p4,
                      input logic e_v, input logic e_f, input logic [1:0] e_c,
                      input logic [31:0] e_fpc, input logic [31:0] e_cnt);
    exp_t e;
    rst_n = r; stall = s; flush = f; pc_src = ps; pc_target = tgt;
    e = '{pc: e_pc, instr: e_instr, ipc: e_ipc, p4: e_p4, v: e_v, f: e_f, c: e_c,
          fpc: e_fpc, cnt: e_cnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc_out", pc_out, e.pc);
    chk("ifid_instr", ifid_instr, e.instr);
    chk("ifid_pc", ifid_pc, e.ipc);
    chk("ifid_pc_plus4", ifid_pc_plus4, e.p4);
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.v});
    chk("fault", {31'b0, fault}, {31'b0, e.f});
    chk("fault_cause", {30'b0, fault_cause}, {30'b0, e.c});
    chk("fault_pc", fault_pc, e.fpc);
    chk("fetch_count", fetch_count, e.cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = word_at(32'(i * 4));
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 1'b0; pc_target = '0;
    @(negedge clk);

    // Reset, then BOOT ignores a redirect and a flush.
    step(0,0,0,0,0,  0, Nop, 0, 0, 0, 0, 2'b00, 0, 0);
    step(0,0,0,0,0,  0, Nop, 0, 0, 0, 0, 2'b00, 0, 0);
    step(1,0,1,1,32'h40,  0, Nop, 0, 0, 0, 0, 2'b00, 0, 0);
    // Sequential fetch.
    step(1,0,0,0,0,  32'h4, 32'h0050_0093, 32'h0, 32'h4, 1, 0, 2'b00, 0, 1);
    step(1,0,0,0,0,  32'h8, 32'h00A0_0113, 32'h4, 32'h8, 1, 0, 2'b00, 0, 2);
    // Three stalls at 0x8, then resume.
    for (int i = 0; i < 3; i++)
      step(1,1,0,0,0,  32'h8, 32'h00A0_0113, 32'h4, 32'h8, 1, 0, 2'b00, 0, 2);
    step(1,0,0,0,0,  32'hC, word_at(32'h8), 32'h8, 32'hC, 1, 0, 2'b00, 0, 3);
    step(1,0,0,0,0,  32'h10, word_at(32'hC), 32'hC, 32'h10, 1, 0, 2'b00, 0, 4);
    // Flush alone at 0x10.
    step(1,0,1,0,0,  32'h14, Nop, 32'hC, 32'h10, 0, 0, 2'b00, 0, 4);
    step(1,0,0,0,0,  32'h18, word_at(32'h14), 32'h14, 32'h18, 1, 0, 2'b00, 0, 5);
    // Redirect beats stall.
    step(1,1,0,1,32'h20,  32'h20, Nop, 32'h14, 32'h18, 0, 0, 2'b00, 0, 5);
    step(1,0,0,0,0,  32'h24, word_at(32'h20), 32'h20, 32'h24, 1, 0, 2'b00, 0, 6);
    // Stall with flush: PC holds, bubble.
    step(1,1,1,0,0,  32'h24, Nop, 32'h20, 32'h24, 0, 0, 2'b00, 0, 6);
    step(1,0,0,0,0,  32'h28, word_at(32'h24), 32'h24, 32'h28, 1, 0, 2'b00, 0, 7);
    // Misaligned redirect, then HALT ignores inputs.
    step(1,0,0,1,32'h22,  32'h28, Nop, 32'h24, 32'h28, 0, 1, 2'b01, 32'h22, 7);
    step(1,0,1,1,32'h40,  32'h28, Nop, 32'h24, 32'h28, 0, 1, 2'b01, 32'h22, 7);
    step(1,0,0,0,0,  32'h28, Nop, 32'h24, 32'h28, 0, 1, 2'b01, 32'h22, 7);
    // Reset out of HALT overrides a concurrent redirect.
    step(0,0,0,1,32'h40,  0, Nop, 0, 0, 0, 0, 2'b00, 0, 0);
    step(1,0,0,0,0,  0, Nop, 0, 0, 0, 0, 2'b00, 0, 0);
    // Run sequentially to the last in-range word, then fall off the end.
    for (int k = 1; k <= 63; k++)
      step(1,0,0,0,0,  32'(4 * k), word_at(32'(4 * (k - 1))), 32'(4 * (k - 1)),
           32'(4 * k), 1, 0, 2'b00, 0, 32'(k));
    step(1,0,0,0,0,  32'hFC, Nop, 32'hF8, 32'hFC, 0, 1, 2'b10, 32'h100, 63);
    // Both fault flags at once.
    step(0,0,0,0,0,  0, Nop, 0, 0, 0, 0, 2'b00, 0, 0);
    step(1,0,0,0,0,  0, Nop, 0, 0, 0, 0, 2'b00, 0, 0);
    step(1,0,0,0,0,  32'h4, 32'h0050_0093, 32'h0, 32'h4, 1, 0, 2'b00, 0, 1);
    step(1,0,0,1,32'h101,  32'h4, Nop, 32'h0, 32'h4, 0, 1, 2'b11, 32'h101, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
